// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Purpose  : Shared types and field positions for the decode pipeline stage
//  Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

    localparam int INSTR_W = 9;
    localparam int OPC_HI  = 8;
    localparam int OPC_LO  = 4;
    localparam int OPC_W   = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] OPC_HALT  = 5'b00000;
    localparam logic [1:0]       IMM_CLASS = 2'b11;

    typedef enum logic [1:0] {
        LUT  = 2'b00,
        SEXT = 2'b01,
        UNS  = 2'b10
    } imm_ctrl_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic             isImm;
        imm_ctrl_t        immCtrl;
        logic             numBits;
        logic [1:0]       immIn0;
        logic [1:0]       immIn1;
    } decoded_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decoder
//  Purpose  : Combinational split of a 9-bit instruction into decoded fields,
//             plus illegal-opcode and HALT detection
//  Revision : 1.0  initial release
// ============================================================================
module instr_decoder
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output decoded_t           o_dec,
    output logic               o_illegal,
    output logic               o_halt
);

    logic [OPC_W-1:0] w_opc;
    logic             w_immClass;

    assign w_opc      = i_instr[OPC_HI:OPC_LO];
    assign w_immClass = (w_opc[4:3] == IMM_CLASS);

    // Field decode; immediate-class opcodes carry size and control in the low bits
    always_comb begin
        o_dec         = '0;
        o_dec.opcode  = w_opc;
        o_dec.immIn0  = i_instr[3:2];
        o_dec.immIn1  = i_instr[1:0];
        o_dec.immCtrl = UNS;
        if (w_immClass) begin
            o_dec.isImm   = 1'b1;
            o_dec.numBits = w_opc[2];
            case (w_opc[1:0])
                2'b00:   o_dec.immCtrl = LUT;
                2'b01:   o_dec.immCtrl = SEXT;
                default: o_dec.immCtrl = UNS;  // 2'b11 is illegal and never forwarded
            endcase
        end
    end

    assign o_illegal = w_immClass && (w_opc[1:0] == 2'b11);
    assign o_halt    = (w_opc == OPC_HALT);

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Registered decode stage with valid/ready handshake, flush,
//             HALT freeze, sticky illegal flag and retired-instruction counter
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8:0]         in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         opcode,
    output logic               is_imm,
    output logic [1:0]         imm_ctrl,
    output logic               num_bits,
    output logic [1:0]         imm_in0,
    output logic [1:0]         imm_in1,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count
);

    state_t           r_state;
    state_t           w_nextState;
    decoded_t         w_dec;
    decoded_t         r_dec;
    logic             w_decIllegal;
    logic             w_decHalt;
    logic             r_outValid;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_legalAccept;
    logic             w_downHs;

    instr_decoder u_decoder (
        .i_instr   (in_instr),
        .o_dec     (w_dec),
        .o_illegal (w_decIllegal),
        .o_halt    (w_decHalt)
    );

    // Ready never looks at in_instr, so no combinational path from the data
    assign in_ready      = !reset && (r_state == RUN) && !flush
                           && (!r_outValid || out_ready);
    assign w_accept      = in_valid && in_ready;
    assign w_legalAccept = w_accept && !w_decIllegal;
    // A handshake coinciding with flush is discarded and not retired
    assign w_downHs      = r_outValid && out_ready && !flush;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_nextState;
    end

    // Next state: a forwarded HALT freezes the stage until reset
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:     if (w_legalAccept && w_decHalt) w_nextState = HALTED;
            HALTED:  w_nextState = HALTED;
            default: w_nextState = RUN;
        endcase
    end

    // Output register: flush wins, then new entry, then drain on handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_dec      <= '0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_legalAccept) begin
            r_outValid <= 1'b1;
            r_dec      <= w_dec;
        end else if (w_accept || out_ready) begin
            // An illegal accept implies the old entry drained (or none existed)
            r_outValid <= 1'b0;
        end
    end

    // Sticky illegal-opcode flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         r_illegal <= 1'b0;
        else if (w_accept && w_decIllegal) r_illegal <= 1'b1;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_count <= '0;
        else if (w_downHs) r_count <= r_count + 1'b1;
    end

    assign out_valid   = r_outValid;
    assign opcode      = r_dec.opcode;
    assign is_imm      = r_dec.isImm;
    assign imm_ctrl    = r_dec.immCtrl;
    assign num_bits    = r_dec.numBits;
    assign imm_in0     = r_dec.immIn0;
    assign imm_in1     = r_dec.immIn1;
    assign halted      = (r_state == HALTED);
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Directed self-checking bench for decode_stage (4-bit counter)
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       opcode;
    logic             is_imm;
    logic [1:0]       imm_ctrl;
    logic             num_bits;
    logic [1:0]       imm_in0;
    logic [1:0]       imm_in1;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    int vectors     = 0;
    int miscompares = 0;
    int expCount    = 0;

    always #5 clk = ~clk;

    decode_stage #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .is_imm      (is_imm),
        .imm_ctrl    (imm_ctrl),
        .num_bits    (num_bits),
        .imm_in0     (imm_in0),
        .imm_in1     (imm_in1),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic [4:0] opc, input logic imm,
                             input logic [1:0] ctrl, input logic nb,
                             input logic [1:0] i0, input logic [1:0] i1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".opcode"},    32'(opcode),    32'(opc));
        chk({tag, ".is_imm"},    32'(is_imm),    32'(imm));
        chk({tag, ".imm_ctrl"},  32'(imm_ctrl),  32'(ctrl));
        chk({tag, ".num_bits"},  32'(num_bits),  32'(nb));
        chk({tag, ".imm_in0"},   32'(imm_in0),   32'(i0));
        chk({tag, ".imm_in1"},   32'(imm_in1),   32'(i1));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // ---- reset state ----
        #2;
        chk("rst.out_valid",   32'(out_valid),   32'd0);
        chk("rst.in_ready",    32'(in_ready),    32'd0);
        chk("rst.imm_ctrl",    32'(imm_ctrl),    32'd0);
        chk("rst.halted",      32'(halted),      32'd0);
        chk("rst.illegal",     32'(illegal),     32'd0);
        chk("rst.instr_count", 32'(instr_count), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // ---- single decode: 11010_11_01 ----
        in_valid = 1'b1; in_instr = 9'b11010_11_01; out_ready = 1'b0;
        #1;
        chk("t1.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        expectOut("t1", 5'b11010, 1'b1, 2'b10, 1'b0, 2'b11, 2'b01);
        out_ready = 1'b1;
        tick();
        expCount++;
        chk("t1.drain", 32'(out_valid), 32'd0);

        // ---- four back-to-back with a two-cycle stall ----
        in_valid = 1'b1; in_instr = 9'b11000_01_10; out_ready = 1'b1;   // A
        tick();
        in_instr = 9'b00101_11_00; out_ready = 1'b0;                    // B waits
        #1;
        chk("t2.stall1.in_ready", 32'(in_ready), 32'd0);
        expectOut("t2.A.c2", 5'b11000, 1'b1, 2'b00, 1'b0, 2'b01, 2'b10);
        tick();
        chk("t2.stall2.in_ready", 32'(in_ready), 32'd0);
        expectOut("t2.A.c3", 5'b11000, 1'b1, 2'b00, 1'b0, 2'b01, 2'b10);
        tick();
        expectOut("t2.A.c4", 5'b11000, 1'b1, 2'b00, 1'b0, 2'b01, 2'b10);
        out_ready = 1'b1;
        #1;
        chk("t2.resume.in_ready", 32'(in_ready), 32'd1);
        tick();
        expCount++;
        expectOut("t2.B", 5'b00101, 1'b0, 2'b10, 1'b0, 2'b11, 2'b00);
        in_instr = 9'b11101_00_11;                                      // C
        tick();
        expCount++;
        expectOut("t2.C", 5'b11101, 1'b1, 2'b01, 1'b1, 2'b00, 2'b11);
        in_instr = 9'b11110_10_01;                                      // D
        tick();
        expCount++;
        expectOut("t2.D", 5'b11110, 1'b1, 2'b10, 1'b1, 2'b10, 2'b01);
        in_valid = 1'b0;
        tick();
        expCount++;
        chk("t2.empty", 32'(out_valid), 32'd0);
        chk("t2.count", 32'(instr_count), 32'(expCount % 16));

        // ---- illegal opcode dropped, sticky flag, then legal follow-up ----
        in_valid = 1'b1; in_instr = 9'b11011_00_00;
        tick();
        in_instr = 9'b11101_10_10;
        chk("t3.dropped", 32'(out_valid), 32'd0);
        chk("t3.illegal", 32'(illegal),   32'd1);
        tick();
        in_valid = 1'b0;
        expectOut("t3.next", 5'b11101, 1'b1, 2'b01, 1'b1, 2'b10, 2'b10);
        chk("t3.sticky", 32'(illegal), 32'd1);
        tick();
        expCount++;
        chk("t3.count", 32'(instr_count), 32'(expCount % 16));

        // ---- flush while stalled with input pending ----
        in_valid = 1'b1; in_instr = 9'b10001_01_01; out_ready = 1'b0;
        tick();
        expectOut("t4.held", 5'b10001, 1'b0, 2'b10, 1'b0, 2'b01, 2'b01);
        in_instr = 9'b11100_00_00; flush = 1'b1;
        #1;
        chk("t4.in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4.out_valid", 32'(out_valid),   32'd0);
        chk("t4.count",     32'(instr_count), 32'(expCount % 16));

        // ---- flush coinciding with a downstream handshake is not counted ----
        in_valid = 1'b1; in_instr = 9'b10001_01_01; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5.out_valid", 32'(out_valid),   32'd0);
        chk("t5.count",     32'(instr_count), 32'(expCount % 16));

        // ---- counter wrap: 17 handshakes into a 4-bit counter ----
        in_valid = 1'b1; in_instr = 9'b00001_00_00; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        in_valid = 1'b0;
        tick();
        expCount += 17;
        chk("t6.wrap", 32'(instr_count), 32'(expCount % 16));

        // ---- HALT held by a stall, then asynchronous reset mid-stall ----
        in_valid = 1'b1; in_instr = 9'b00000_00_00; out_ready = 1'b0;
        tick();
        in_instr = 9'b00001_00_00;
        expectOut("t7.halt", 5'b00000, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00);
        chk("t7.halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            out_ready = (i % 2 == 1) ? 1'b0 : 1'b0;
            chk("t7.frozen.in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("t7.still_held", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7.rst.out_valid",   32'(out_valid),   32'd0);
        chk("t7.rst.in_ready",    32'(in_ready),    32'd0);
        chk("t7.rst.opcode",      32'(opcode),      32'd0);
        chk("t7.rst.imm_ctrl",    32'(imm_ctrl),    32'd0);
        chk("t7.rst.halted",      32'(halted),      32'd0);
        chk("t7.rst.illegal",     32'(illegal),     32'd0);
        chk("t7.rst.instr_count", 32'(instr_count), 32'd0);
        expCount = 0;
        tick();
        reset = 1'b0;

        // ---- HALT delivered, flush does not leave HALTED ----
        in_valid = 1'b1; in_instr = 9'b00000_00_00; out_ready = 1'b0;
        tick();
        in_instr = 9'b00001_00_00;
        chk("t8.halted", 32'(halted), 32'd1);
        out_ready = 1'b1;
        tick();
        expCount++;
        chk("t8.delivered", 32'(out_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t8.flush.halted",   32'(halted),      32'd1);
        chk("t8.flush.in_ready", 32'(in_ready),    32'd0);
        chk("t8.flush.empty",    32'(out_valid),   32'd0);
        chk("t8.count",          32'(instr_count), 32'(expCount % 16));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
